// File: rtl/top_digital.sv
// top_digital: digital core of the mixed-signal sensor chip.
// Serial register port on TCK/TDI/TDO, AFE sequencer (mux select, hall
// spinning, ADC soc/eoc handshake) and 14-bit result accumulator.
// Optional result streaming over UART is built when TOP_DIGITAL_UART_EN
// is defined; otherwise ms_utx is tied high.
module top_digital #(
    parameter int unsigned SETTLE_CYC = 8,
    parameter int unsigned BAUD_DIV   = 174,
    parameter logic [15:0] ID_VALUE   = 16'hA5C1
) (
    input  logic        ms_osc,
    input  logic        ms_hporb,
    input  logic        ms_trstb,
    input  logic        ms_tck,
    input  logic        ms_tdi,
    output logic        ms_tdo,
    output logic        ms_tde,
    input  logic        ms_adc_eoc,
    input  logic [11:0] ms_adc_data,
    output logic        ms_adc_soc,
    output logic        ms_adc_clk,
    output logic [3:0]  ms_afe_sel,
    output logic [3:0]  ms_afe_phase,
    output logic        ms_afe_phase_update,
    input  logic        ms_urx,
    output logic        ms_utx
);
    typedef enum logic [2:0] {
        S_IDLE, S_PHASE, S_SETTLE, S_SOC, S_WAIT, S_ACC, S_DONE
    } seq_state_t;

    localparam int unsigned CW = (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] SOC_LAST    = CW'(1);

    logic [1:0]  tck_sync, tdi_sync, trst_sync;
    logic        tck_d, tck_rise, tck_fall, trst_n;
    logic [4:0]  bit_cnt, out_left;
    logic [22:0] sh_in;
    logic [23:0] sh_next;
    logic [15:0] rd_sh, rd_value;
    logic        ctrl_cont, ctrl_spin, start_pulse, status_rd;
    logic [3:0]  ctrl_sel;
    seq_state_t  state;
    logic        busy, done, eoc_d;
    logic [13:0] acc, result;
    logic [1:0]  conv_cnt;
    logic [CW-1:0] wait_cnt;
    logic        unused_sigs;

    assign unused_sigs = ms_urx | (BAUD_DIV == 0);

    // Synchronise the test pins into the ms_osc domain and keep TCK history
    always_ff @(posedge ms_osc or negedge ms_hporb) begin
        if (!ms_hporb) begin
            tck_sync  <= '0;
            tdi_sync  <= '0;
            trst_sync <= '0;
            tck_d     <= 1'b0;
        end else begin
            tck_sync  <= {tck_sync[0], ms_tck};
            tdi_sync  <= {tdi_sync[0], ms_tdi};
            trst_sync <= {trst_sync[0], ms_trstb};
            tck_d     <= tck_sync[1];
        end
    end

    assign tck_rise = tck_sync[1] & ~tck_d;
    assign tck_fall = ~tck_sync[1] & tck_d;
    assign trst_n   = trst_sync[1];
    assign sh_next  = {sh_in, tdi_sync[1]};

    // Read mux, addressed by the 7 address bits just completed at bit 8
    always_comb begin
        case (sh_next[6:0])
            7'h00:   rd_value = {8'h00, ctrl_sel, 1'b0, ctrl_spin, ctrl_cont, 1'b0};
            7'h01:   rd_value = {14'h0000, done, busy};
            7'h02:   rd_value = {2'b00, result};
            7'h03:   rd_value = ID_VALUE;
            default: rd_value = '0;
        endcase
    end

    // Clear sticky done in the same cycle the STATUS value is captured, so a
    // done set in that cycle survives to the next read.
    assign status_rd = trst_n && tck_rise && (bit_cnt == 5'd7) &&
                       !sh_next[7] && (sh_next[6:0] == 7'h01);

    // Serial frame: shift in on TCK rise, load read data at bit 8, write at bit 24
    always_ff @(posedge ms_osc or negedge ms_hporb) begin
        if (!ms_hporb) begin
            bit_cnt     <= '0;
            out_left    <= '0;
            sh_in       <= '0;
            rd_sh       <= '0;
            ms_tdo      <= 1'b0;
            ms_tde      <= 1'b0;
            ctrl_cont   <= 1'b0;
            ctrl_spin   <= 1'b0;
            ctrl_sel    <= '0;
            start_pulse <= 1'b0;
        end else begin
            start_pulse <= 1'b0;
            if (!trst_n) begin
                bit_cnt  <= '0;
                out_left <= '0;
                ms_tde   <= 1'b0;
            end else begin
                if (tck_rise) begin
                    sh_in <= sh_next[22:0];
                    if (bit_cnt == 5'd23) begin
                        bit_cnt <= '0;
                        if (sh_next[23] && (sh_next[22:16] == 7'h00)) begin
                            ctrl_cont   <= sh_next[1];
                            ctrl_spin   <= sh_next[2];
                            ctrl_sel    <= sh_next[7:4];
                            start_pulse <= sh_next[0];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 5'd1;
                        if ((bit_cnt == 5'd7) && !sh_next[7]) begin
                            rd_sh    <= rd_value;
                            out_left <= 5'd16;
                        end
                    end
                end
                if (tck_fall) begin
                    if (out_left != '0) begin
                        ms_tdo   <= rd_sh[15];
                        rd_sh    <= {rd_sh[14:0], 1'b0};
                        out_left <= out_left - 5'd1;
                        ms_tde   <= 1'b1;
                    end else begin
                        ms_tde <= 1'b0;
                    end
                end
            end
        end
    end

    assign ms_afe_sel = ctrl_sel;

    // ADC clock at half the oscillator rate
    always_ff @(posedge ms_osc or negedge ms_hporb) begin
        if (!ms_hporb) ms_adc_clk <= 1'b0;
        else           ms_adc_clk <= ~ms_adc_clk;
    end

    // Measurement sequencer: phase, settle, soc, wait eoc, accumulate, done
    always_ff @(posedge ms_osc or negedge ms_hporb) begin
        if (!ms_hporb) begin
            state               <= S_IDLE;
            ms_afe_phase        <= 4'b0001;
            ms_afe_phase_update <= 1'b0;
            ms_adc_soc          <= 1'b0;
            busy                <= 1'b0;
            done                <= 1'b0;
            acc                 <= '0;
            result              <= '0;
            conv_cnt            <= '0;
            wait_cnt            <= '0;
            eoc_d               <= 1'b0;
        end else begin
            eoc_d               <= ms_adc_eoc;
            ms_afe_phase_update <= 1'b0;
            if (state == S_DONE)  done <= 1'b1;
            else if (status_rd)   done <= 1'b0;
            case (state)
                S_IDLE: if (start_pulse) begin
                    state    <= S_PHASE;
                    busy     <= 1'b1;
                    acc      <= '0;
                    conv_cnt <= '0;
                end
                S_PHASE: begin
                    ms_afe_phase_update <= 1'b1;
                    wait_cnt            <= '0;
                    state               <= S_SETTLE;
                end
                S_SETTLE: if (wait_cnt == SETTLE_LAST) begin
                    wait_cnt   <= '0;
                    ms_adc_soc <= 1'b1;
                    state      <= S_SOC;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
                S_SOC: if (wait_cnt == SOC_LAST) begin
                    ms_adc_soc <= 1'b0;
                    state      <= S_WAIT;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
                S_WAIT: if (ms_adc_eoc && !eoc_d) state <= S_ACC;
                S_ACC: begin
                    acc      <= acc + {2'b00, ms_adc_data};
                    conv_cnt <= conv_cnt + 2'd1;
                    if (ctrl_spin) begin
                        ms_afe_phase <= {ms_afe_phase[2:0], ms_afe_phase[3]};
                        state        <= (conv_cnt == 2'd3) ? S_DONE : S_PHASE;
                    end else begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    result <= acc;
                    busy   <= ctrl_cont;
                    if (ctrl_cont) begin
                        state    <= S_PHASE;
                        acc      <= '0;
                        conv_cnt <= '0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef TOP_DIGITAL_UART_EN
    localparam int unsigned BW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

    logic [18:0]   tx_sh;
    logic [4:0]    tx_bits;
    logic [BW-1:0] baud_cnt;
    logic          tx_active;

    // Both bytes go out as one 20-bit LSB-first stream: start, high byte, stop, start, low byte, stop
    always_ff @(posedge ms_osc or negedge ms_hporb) begin
        if (!ms_hporb) begin
            tx_sh     <= '0;
            tx_bits   <= '0;
            baud_cnt  <= '0;
            tx_active <= 1'b0;
            ms_utx    <= 1'b1;
        end else if (!tx_active) begin
            if (state == S_DONE) begin
                tx_sh     <= {1'b1, acc[7:0], 1'b0, 1'b1, 2'b00, acc[13:8]};
                tx_bits   <= 5'd19;
                baud_cnt  <= '0;
                tx_active <= 1'b1;
                ms_utx    <= 1'b0;
            end
        end else if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (tx_bits != '0) begin
                ms_utx  <= tx_sh[0];
                tx_sh   <= {1'b0, tx_sh[18:1]};
                tx_bits <= tx_bits - 5'd1;
            end else begin
                tx_active <= 1'b0;
            end
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end
`else
    assign ms_utx = 1'b1;
`endif

endmodule

// File: tb/tb_top_digital.sv
// Scoreboard bench for top_digital: register reads push expected words,
// a TDO monitor pops and compares each completed 16-bit read.
module tb_top_digital;
    localparam int unsigned BAUD = 16;

    logic        ms_osc = 1'b0, ms_hporb = 1'b1, ms_trstb = 1'b0;
    logic        ms_tck = 1'b0, ms_tdi = 1'b0, ms_adc_eoc = 1'b0, ms_urx = 1'b1;
    logic [11:0] ms_adc_data = '0;
    logic        ms_tdo, ms_tde, ms_adc_soc, ms_adc_clk, ms_afe_phase_update, ms_utx;
    logic [3:0]  ms_afe_sel, ms_afe_phase;

    int total = 0, bad = 0;
    string       name_q[$];
    logic [15:0] val_q[$];
    int          soc_count = 0, upd_count = 0;
    logic [3:0]  phase_log[$];
    logic [11:0] adc_seq[$];
    logic [11:0] adc_fixed = '0;
    logic        utx_low = 1'b0;

    top_digital #(.SETTLE_CYC(8), .BAUD_DIV(BAUD), .ID_VALUE(16'hA5C1)) dut (
        .ms_osc(ms_osc), .ms_hporb(ms_hporb), .ms_trstb(ms_trstb),
        .ms_tck(ms_tck), .ms_tdi(ms_tdi), .ms_tdo(ms_tdo), .ms_tde(ms_tde),
        .ms_adc_eoc(ms_adc_eoc), .ms_adc_data(ms_adc_data),
        .ms_adc_soc(ms_adc_soc), .ms_adc_clk(ms_adc_clk),
        .ms_afe_sel(ms_afe_sel), .ms_afe_phase(ms_afe_phase),
        .ms_afe_phase_update(ms_afe_phase_update),
        .ms_urx(ms_urx), .ms_utx(ms_utx)
    );

    always #5 ms_osc = ~ms_osc;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp_v);
        end
    endtask

    // ADC model: eoc cleared by soc, result after 11 adc_clk falling edges
    initial forever begin
        @(posedge ms_adc_soc);
        soc_count++;
        @(negedge ms_osc);
        ms_adc_eoc = 1'b0;
        repeat (11) @(negedge ms_adc_clk);
        @(negedge ms_osc);
        if (adc_seq.size() > 0) ms_adc_data = adc_seq.pop_front();
        else                    ms_adc_data = adc_fixed;
        ms_adc_eoc = 1'b1;
    end

    always @(negedge ms_osc) begin
        if (ms_afe_phase_update) begin
            upd_count++;
            phase_log.push_back(ms_afe_phase);
        end
        if (!ms_utx) utx_low = 1'b1;
    end

    // TDO monitor: gathers bits while tde is high and checks each 16-bit word
    initial begin
        logic [15:0] shv;
        int n;
        shv = '0;
        n = 0;
        forever begin
            @(posedge ms_tck);
            if (ms_tde) begin
                shv = {shv[14:0], ms_tdo};
                n++;
                if (n == 16) begin
                    if (name_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL tdo_unexpected: got 0x%0h, want no read", shv);
                    end else begin
                        check(name_q.pop_front(), {16'h0, shv}, {16'h0, val_q.pop_front()});
                    end
                end else if (n > 16) begin
                    total++; bad++;
                    $display("FAIL tde_length: got %0d bits, want 16", n);
                end
            end else begin
                n = 0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic frame(input logic w, input logic [6:0] addr, input logic [15:0] data, input int nbits);
        logic [23:0] f;
        f = {w, addr, data};
        for (int i = 23; i > 23 - nbits; i--) begin
            @(negedge ms_osc);
            ms_tdi = f[i];
            repeat (4) @(negedge ms_osc);
            ms_tck = 1'b1;
            repeat (4) @(negedge ms_osc);
            ms_tck = 1'b0;
        end
        repeat (8) @(negedge ms_osc);
    endtask

    task automatic reg_write(input logic [6:0] addr, input logic [15:0] data);
        frame(1'b1, addr, data, 24);
    endtask

    task automatic reg_read(input string nm, input logic [6:0] addr, input logic [15:0] exp_v);
        name_q.push_back(nm);
        val_q.push_back(exp_v);
        frame(1'b0, addr, 16'h0000, 24);
        check({nm, "_tde_off"}, {31'h0, ms_tde}, 32'h0);
    endtask

    task automatic wait_soc(input string nm, input int target, input int budget);
        int c;
        c = 0;
        while (soc_count < target && c < budget) begin
            @(negedge ms_osc);
            c++;
        end
        check(nm, {31'h0, soc_count >= target}, 32'h1);
    endtask

`ifdef TOP_DIGITAL_UART_EN
    task automatic uart_byte(input string nm, input logic [7:0] exp_v);
        logic [7:0] b;
        int c;
        c = 0;
        b = '0;
        while (ms_utx && c < 4000) begin
            @(negedge ms_osc);
            c++;
        end
        check({nm, "_start_seen"}, {31'h0, ms_utx}, 32'h0);
        repeat (BAUD / 2) @(negedge ms_osc);
        check({nm, "_start_mid"}, {31'h0, ms_utx}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            repeat (BAUD) @(negedge ms_osc);
            b[i] = ms_utx;
        end
        check(nm, {24'h0, b}, {24'h0, exp_v});
        repeat (BAUD) @(negedge ms_osc);
        check({nm, "_stop"}, {31'h0, ms_utx}, 32'h1);
    endtask
`endif

    initial begin
        int soc0, upd0, s1;
        logic [3:0] exp_ph [4];
        exp_ph = '{4'h1, 4'h2, 4'h4, 4'h8};

        // reset values
        #2 ms_hporb = 1'b0;
        repeat (4) @(negedge ms_osc);
        check("rst_tdo", {31'h0, ms_tdo}, 32'h0);
        check("rst_tde", {31'h0, ms_tde}, 32'h0);
        check("rst_soc", {31'h0, ms_adc_soc}, 32'h0);
        check("rst_adc_clk", {31'h0, ms_adc_clk}, 32'h0);
        check("rst_sel", {28'h0, ms_afe_sel}, 32'h0);
        check("rst_phase", {28'h0, ms_afe_phase}, 32'h1);
        check("rst_upd", {31'h0, ms_afe_phase_update}, 32'h0);
        check("rst_utx", {31'h0, ms_utx}, 32'h1);
        ms_hporb = 1'b1;
        ms_trstb = 1'b1;
        repeat (6) @(negedge ms_osc);

        // register map
        reg_read("id", 7'h03, 16'hA5C1);
        reg_read("ctrl_rst", 7'h00, 16'h0000);
        reg_read("status_rst", 7'h01, 16'h0000);
        reg_read("result_rst", 7'h02, 16'h0000);
        reg_read("unmapped", 7'h10, 16'h0000);
        reg_write(7'h03, 16'hFFFF);
        reg_read("id_ro", 7'h03, 16'hA5C1);

        // serial reset aborts a partial write frame
        frame(1'b1, 7'h00, 16'h00F0, 5);
        @(negedge ms_osc) ms_trstb = 1'b0;
        repeat (5) @(negedge ms_osc);
        ms_trstb = 1'b1;
        repeat (5) @(negedge ms_osc);
        reg_read("id_after_trst", 7'h03, 16'hA5C1);
        reg_read("ctrl_after_trst", 7'h00, 16'h0000);

        // single conversion, sel=1
        soc0 = soc_count;
        adc_seq.push_back(12'h400);
        reg_write(7'h00, 16'h0011);
        check("sel1", {28'h0, ms_afe_sel}, 32'h1);
        wait_soc("single_soc_seen", soc0 + 1, 300);
        repeat (80) @(negedge ms_osc);
        check("single_soc_count", soc_count - soc0, 32'd1);
        check("single_phase", {28'h0, ms_afe_phase}, 32'h1);
        reg_read("single_result", 7'h02, 16'h0400);
        reg_read("single_status", 7'h01, 16'h0002);
        reg_read("status_cleared", 7'h01, 16'h0000);
        reg_read("ctrl_start_clr", 7'h00, 16'h0010);

        // spinning, 4 conversions
        soc0 = soc_count;
        upd0 = upd_count;
        phase_log.delete();
        adc_seq.push_back(12'd100);
        adc_seq.push_back(12'd200);
        adc_seq.push_back(12'd300);
        adc_seq.push_back(12'd400);
        reg_write(7'h00, 16'h0045);
        wait_soc("spin_soc_seen", soc0 + 4, 1000);
        repeat (80) @(negedge ms_osc);
        check("spin_upd_count", upd_count - upd0, 32'd4);
        check("spin_log_size", phase_log.size(), 32'd4);
        if (phase_log.size() == 4)
            for (int i = 0; i < 4; i++)
                check($sformatf("spin_phase%0d", i), {28'h0, phase_log[i]}, {28'h0, exp_ph[i]});
        check("spin_phase_end", {28'h0, ms_afe_phase}, 32'h1);
        check("sel4", {28'h0, ms_afe_sel}, 32'h4);
        reg_read("spin_result", 7'h02, 16'd1000);
        reg_read("spin_status", 7'h01, 16'h0002);

        // continuous at full scale, then clear continuous
        soc0 = soc_count;
        adc_fixed = 12'hFFF;
        reg_write(7'h00, 16'h0007);
        wait_soc("cont_soc_seen", soc0 + 8, 2000);
        reg_read("cont_result", 7'h02, 16'h3FFC);
        reg_write(7'h00, 16'h0004);
        repeat (400) @(negedge ms_osc);
        s1 = soc_count;
        repeat (300) @(negedge ms_osc);
        check("cont_stopped", soc_count, s1);
        check("cont_whole_meas", (soc_count - soc0) % 4, 32'd0);
        reg_read("cont_status", 7'h01, 16'h0002);
        reg_read("cont_result_end", 7'h02, 16'h3FFC);

        // hard reset in WAIT
        soc0 = soc_count;
        adc_fixed = 12'h010;
        reg_write(7'h00, 16'h0005);
        wait_soc("rstw_soc_seen", soc0 + 2, 600);
        repeat (4) @(negedge ms_osc);
        check("rstw_phase_pre", {28'h0, ms_afe_phase}, 32'h2);
        @(negedge ms_osc) ms_hporb = 1'b0;
        #1;
        check("rstw_soc", {31'h0, ms_adc_soc}, 32'h0);
        check("rstw_phase", {28'h0, ms_afe_phase}, 32'h1);
        check("rstw_sel", {28'h0, ms_afe_sel}, 32'h0);
        repeat (3) @(negedge ms_osc);
        ms_hporb = 1'b1;
        repeat (80) @(negedge ms_osc);
        check("rstw_phase_post", {28'h0, ms_afe_phase}, 32'h1);
        reg_read("rstw_status", 7'h01, 16'h0000);
        reg_read("rstw_ctrl", 7'h00, 16'h0000);
        reg_read("rstw_result", 7'h02, 16'h0000);

`ifdef TOP_DIGITAL_UART_EN
        // UART streams RESULT 0x1234 as 0x12 then 0x34
        repeat (4) adc_seq.push_back(12'd1165);
        reg_write(7'h00, 16'h0005);
        uart_byte("uart_hi", 8'h12);
        uart_byte("uart_lo", 8'h34);
        reg_read("uart_result", 7'h02, 16'h1234);
`else
        check("utx_idle", {31'h0, utx_low}, 32'h0);
`endif

        check("sb_drained", name_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/top_digital.md
# top_digital

Digital core of the mixed-signal sensor chip, clocked by the on-chip oscillator. It exposes a serial register port on the test pins (TCK/TDI/TDO) and runs the analog front end: channel mux select, hall-plate current spinning, and ADC start/end-of-conversion handshake. It accumulates conversion results into a result register. An optional UART streams each result.

## Interface
Parameters:
- SETTLE_CYC, 8: ms_osc cycles between a phase/mux change and ADC start.
- BAUD_DIV, 174: ms_osc cycles per UART bit.
- ID_VALUE, 16'hA5C1: value of the read-only ID register.

Ports:
- ms_osc  in  1  system clock; all logic on its rising edge.
- ms_hporb  in  1  reset, asynchronous, active-low.
- ms_trstb  in  1  serial port reset, active-low, synchronised.
- ms_tck  in  1  serial clock; oversampled, 2-flop sync plus edge detect.
- ms_tdi  in  1  serial data in.
- ms_tdo  out  1  serial data out.
- ms_tde  out  1  ms_tdo drive enable.
- ms_adc_eoc  in  1  ADC end of conversion; a level that is cleared by soc.
- ms_adc_data  in  12  ADC result, valid while eoc=1.
- ms_adc_soc  out  1  ADC start of conversion.
- ms_adc_clk  out  1  ADC clock, ms_osc/2.
- ms_afe_sel  out  4  analog mux select.
- ms_afe_phase  out  4  one-hot hall spinning phase.
- ms_afe_phase_update  out  1  one-cycle strobe after a phase change.
- ms_urx  in  1  UART RX (unused, ignored).
- ms_utx  out  1  UART TX, idle high.

## Operation
- Reset values:
  - Outputs: ms_tdo=0, ms_tde=0, ms_adc_soc=0, ms_adc_clk=0, ms_afe_sel=0, ms_afe_phase=4'b0001, ms_afe_phase_update=0, ms_utx=1.
  - Registers: all 0.
- Serial frame (24 TCK rising edges, MSB first): bit23 = write, bits22:16 = addr, bits15:0 = data.
  - TDI is sampled on TCK rise.
  - Write: the register is updated at bit 24.
  - Read: after bit 8, the register value is loaded. Its 16 bits are shifted out on TDO on the following TCK falls, with ms_tde=1 during those 16 bits.
  - ms_trstb=0 clears the bit counter and ms_tde.
- Registers:
  - 0x00 CTRL: bit0 start (self-clearing), bit1 continuous, bit2 spin_en, bits7:4 sel.
  - 0x01 STATUS (RO): bit0 busy, bit1 done. done is sticky and cleared by a STATUS read.
  - 0x02 RESULT (RO): 14 bits, zero-extended to 16.
  - 0x03 ID (RO): ID_VALUE.
  - Other addresses: reads return 0, writes are ignored.
- ms_afe_sel mirrors CTRL.sel at all times.
- Sequencer FSM:
  - IDLE: on start, go to PHASE, set busy, clear the accumulator.
  - PHASE: drive ms_afe_phase, pulse ms_afe_phase_update, go to SETTLE.
  - SETTLE: wait SETTLE_CYC cycles, go to SOC.
  - SOC: hold ms_adc_soc=1 for 2 cycles, go to WAIT.
  - WAIT: wait for the rising edge of ms_adc_eoc, go to ACC.
  - ACC: add ms_adc_data to the accumulator.
    - spin_en=1: rotate the phase 0001→0010→0100→1000. Go back to PHASE until 4 conversions are done.
    - spin_en=0: exactly one conversion, and the phase stays unchanged.
  - DONE: RESULT←accumulator, done=1, busy=0.
    - continuous=1: restart at PHASE.
    - continuous=0: go to IDLE.
- Start while busy is ignored.
- Clearing continuous ends the sequence after the current measurement.
- 4×4095 = 16380 fits in 14 bits, so there is no overflow.
- A STATUS read in the same cycle that done is set leaves done=1.

## Timing
- ms_adc_clk toggles every ms_osc cycle.
- The ADC responds 11 adc_clk falling edges after soc. Worst-case eoc latency from soc rise is about 24 ms_osc cycles.
- Per conversion: 1 (PHASE) + SETTLE_CYC + 2 (SOC) + eoc latency + 1 (ACC).
- A register write takes effect 3–4 ms_osc cycles after the 24th TCK rise (sync latency).
- TCK high and low times must each be at least 3 ms_osc cycles.
- Reset asserted mid-operation returns everything to the reset values immediately.

## Configuration
- TOP_DIGITAL_UART_EN defined:
  - On each DONE, send RESULT as two 8N1 bytes: high byte {2'b00, RESULT[13:8]}, then the low byte.
  - Bit time is BAUD_DIV cycles.
  - A new DONE during transmission is dropped.
- Not defined: ms_utx is constant 1 and no UART logic is present.

## Test plan
- Reset, then read 0x03 → TDO returns 16'hA5C1 and ms_tde is high for exactly 16 TCK falls.
- Write CTRL = 16'h0011 (sel=1, start), ADC returns 12'h400 → ms_afe_sel=1, one soc, RESULT=0x0400, STATUS=0x0002. A second STATUS read returns 0x0000.
- Write CTRL = 16'h0045 (sel=4, spin, start), ADC returns 100/200/300/400 → phase sequence 0001, 0010, 0100, 1000 with 4 phase_update strobes, RESULT=1000. The phase ends at 0001.
- Continuous mode with ADC fixed at 12'hFFF and spin on → RESULT=16380 repeatedly. Clearing continuous stops the sequence after the current measurement.
- Assert ms_hporb low during WAIT → soc=0 and phase=0001 immediately, busy=0 after release.
- With TOP_DIGITAL_UART_EN, RESULT=0x1234 → ms_utx sends bytes 0x12 then 0x34, each bit BAUD_DIV cycles wide.
